match_ctrl: RTL

- Parametrised match controller for the pong datapath. It replaces the fixed 9-point scoring and freeze logic.
- Consumes ball events (out_left, out_right, hit). Drives ball speed, ball_reset and serve direction.
- Keeps scores with configurable win score and win-by margin. Adds rally speed ramp and player pause.
- The ball instance sits outside this block; its events feed in here and speed/ball_reset feed back to it.

---
 rtl/match_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/match_ctrl.sv
// Match controller for the pong datapath: serve/freeze sequencing, scoring
// with configurable win score and margin, rally speed ramp and player pause.
// The ball itself lives outside; its edge/hit events arrive here and the
// speed/ball_reset outputs steer it.
module match_ctrl #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int WIN_BY       = 1,
   parameter int SPEED_W      = 4,
   parameter int SPEED_MAX    = 15,
   parameter int RAMP_HITS    = 4,
   parameter int FREEZE_W     = 17,
   parameter int POINT_FREEZE = 8000,
   parameter int GAME_FREEZE  = 131071
) (
   input  logic               game_clk,
   input  logic               reset,
   input  logic               start,
   input  logic               pause,
   input  logic               out_left,
   input  logic               out_right,
   input  logic               hit,
   input  logic [SPEED_W-1:0] difficulty,
   output logic [SPEED_W-1:0] speed,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic               game_over,
   output logic               winner,
   output logic               paused
);

   // Rally counter must hold RAMP_HITS; keep at least one bit when the ramp is off.
   localparam int RALLY_W = (RAMP_HITS < 2) ? 1 : $clog2(RAMP_HITS + 1);

   localparam logic [SCORE_W-1:0]  WIN_SCORE_L = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0]  WIN_BY_L    = SCORE_W'(WIN_BY);
   localparam logic [SCORE_W-1:0]  SCORE_ONE   = {{(SCORE_W-1){1'b0}}, 1'b1};
   localparam logic [SCORE_W-1:0]  SCORE_SAT   = {SCORE_W{1'b1}};
   localparam logic [SPEED_W-1:0]  SPEED_MAX_L = SPEED_W'(SPEED_MAX);
   localparam logic [SPEED_W-1:0]  SPEED_ZERO  = {SPEED_W{1'b0}};
   localparam logic [FREEZE_W-1:0] CNT_ONE     = {{(FREEZE_W-1){1'b0}}, 1'b1};
   localparam logic [FREEZE_W-1:0] CNT_ZERO    = {FREEZE_W{1'b0}};
   localparam logic [FREEZE_W-1:0] CNT_GAME    = FREEZE_W'(GAME_FREEZE);
   localparam logic [FREEZE_W-1:0] CNT_POINT   = FREEZE_W'(POINT_FREEZE);
   localparam logic [RALLY_W-1:0]  RALLY_ZERO  = {RALLY_W{1'b0}};
   localparam logic [RALLY_W-1:0]  RALLY_ONE   = {{(RALLY_W-1){1'b0}}, 1'b1};
   localparam logic [RALLY_W-1:0]  RALLY_TOP   = RALLY_W'(RAMP_HITS);

   typedef enum logic [1:0] {
      FREEZE = 2'd0,
      SERVE  = 2'd1,
      PLAY   = 2'd2,
      PAUSED = 2'd3
   } state_t;

   state_t               state_q,       state_d;
   logic [FREEZE_W-1:0]  frz_cnt_q,     frz_cnt_d;
   logic [SCORE_W-1:0]   score_p1_q,    score_p1_d;
   logic [SCORE_W-1:0]   score_p2_q,    score_p2_d;
   logic [SPEED_W-1:0]   speed_q,       speed_d;
   logic [SPEED_W-1:0]   saved_speed_q, saved_speed_d;
   logic [RALLY_W-1:0]   rally_q,       rally_d;
   logic                 ball_reset_q,  ball_reset_d;
   logic                 serve_dir_q,   serve_dir_d;
   logic                 game_over_q,   game_over_d;
   logic                 winner_q,      winner_d;
   logic                 paused_q,      paused_d;

   logic [SCORE_W-1:0]   p1_inc_s;
   logic [SCORE_W-1:0]   p2_inc_s;
   logic [SPEED_W-1:0]   serve_speed_s;
   logic [SPEED_W:0]     speed_wide_s;
   logic [SPEED_W-1:0]   ramp_speed_s;
   logic [RALLY_W-1:0]   rally_inc_s;

   // A scorer wins on reaching the win score with the required lead, or on
   // hitting the counter ceiling so the score can never wrap.
   function automatic logic wins(input logic [SCORE_W-1:0] mine,
                                 input logic [SCORE_W-1:0] opp);
      logic lead_ok;
      lead_ok = (mine > opp) && ((mine - opp) >= WIN_BY_L);
      return ((mine >= WIN_SCORE_L) && lead_ok) || (mine == SCORE_SAT);
   endfunction

   // Arithmetic shared by the state machine: incremented scores, clamped speeds.
   always_comb begin
      p1_inc_s      = score_p1_q + SCORE_ONE;
      p2_inc_s      = score_p2_q + SCORE_ONE;
      serve_speed_s = (difficulty > SPEED_MAX_L) ? SPEED_MAX_L : difficulty;
      speed_wide_s  = {1'b0, speed_q} + {{SPEED_W{1'b0}}, 1'b1};
      ramp_speed_s  = (speed_wide_s > {1'b0, SPEED_MAX_L}) ? SPEED_MAX_L
                                                            : speed_wide_s[SPEED_W-1:0];
      rally_inc_s   = rally_q + RALLY_ONE;
   end

   // Next-state and next-output logic for the match state machine.
   always_comb begin
      state_d       = state_q;
      frz_cnt_d     = frz_cnt_q;
      score_p1_d    = score_p1_q;
      score_p2_d    = score_p2_q;
      speed_d       = speed_q;
      saved_speed_d = saved_speed_q;
      rally_d       = rally_q;
      serve_dir_d   = serve_dir_q;
      game_over_d   = game_over_q;
      winner_d      = winner_q;
      paused_d      = paused_q;

      case (state_q)
         FREEZE: begin
            speed_d = SPEED_ZERO;
            if (frz_cnt_q == CNT_ONE) begin
               state_d   = SERVE;
               frz_cnt_d = CNT_ZERO;
               if (game_over_q) begin
                  score_p1_d  = {SCORE_W{1'b0}};
                  score_p2_d  = {SCORE_W{1'b0}};
                  game_over_d = 1'b0;
               end else begin
                  game_over_d = game_over_q;
               end
            end else if (start) begin
               frz_cnt_d = CNT_ONE;
            end else begin
               frz_cnt_d = frz_cnt_q - CNT_ONE;
            end
         end
         SERVE: begin
            rally_d = RALLY_ZERO;
            speed_d = serve_speed_s;
            state_d = PLAY;
         end
         PLAY: begin
            if (out_left) begin
               score_p1_d  = p1_inc_s;
               serve_dir_d = 1'b0;
               speed_d     = SPEED_ZERO;
               state_d     = FREEZE;
               if (wins(p1_inc_s, score_p2_q)) begin
                  game_over_d = 1'b1;
                  winner_d    = 1'b0;
                  frz_cnt_d   = CNT_GAME;
               end else begin
                  frz_cnt_d   = CNT_POINT;
               end
            end else if (out_right) begin
               score_p2_d  = p2_inc_s;
               serve_dir_d = 1'b1;
               speed_d     = SPEED_ZERO;
               state_d     = FREEZE;
               if (wins(p2_inc_s, score_p1_q)) begin
                  game_over_d = 1'b1;
                  winner_d    = 1'b1;
                  frz_cnt_d   = CNT_GAME;
               end else begin
                  frz_cnt_d   = CNT_POINT;
               end
            end else if (pause) begin
               saved_speed_d = speed_q;
               speed_d       = SPEED_ZERO;
               paused_d      = 1'b1;
               state_d       = PAUSED;
            end else if (hit && (RAMP_HITS != 0)) begin
               if (rally_inc_s == RALLY_TOP) begin
                  rally_d = RALLY_ZERO;
                  speed_d = ramp_speed_s;
               end else begin
                  rally_d = rally_inc_s;
               end
            end else begin
               state_d = PLAY;
            end
         end
         PAUSED: begin
            if (pause) begin
               speed_d  = saved_speed_q;
               paused_d = 1'b0;
               state_d  = PLAY;
            end else begin
               speed_d  = SPEED_ZERO;
            end
         end
         default: begin
            state_d   = FREEZE;
            frz_cnt_d = CNT_GAME;
            speed_d   = SPEED_ZERO;
         end
      endcase

      // ball_reset is registered so it is high exactly while the state is SERVE.
      ball_reset_d = (state_d == SERVE);
   end

   // State and output registers with synchronous reset to the game-start freeze.
   always_ff @(posedge game_clk) begin
      if (reset) begin
         state_q       <= FREEZE;
         frz_cnt_q     <= CNT_GAME;
         score_p1_q    <= {SCORE_W{1'b0}};
         score_p2_q    <= {SCORE_W{1'b0}};
         speed_q       <= SPEED_ZERO;
         saved_speed_q <= SPEED_ZERO;
         rally_q       <= RALLY_ZERO;
         ball_reset_q  <= 1'b1;
         serve_dir_q   <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= 1'b0;
         paused_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         frz_cnt_q     <= frz_cnt_d;
         score_p1_q    <= score_p1_d;
         score_p2_q    <= score_p2_d;
         speed_q       <= speed_d;
         saved_speed_q <= saved_speed_d;
         rally_q       <= rally_d;
         ball_reset_q  <= ball_reset_d;
         serve_dir_q   <= serve_dir_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
         paused_q      <= paused_d;
      end
   end

   assign speed      = speed_q;
   assign ball_reset = ball_reset_q;
   assign serve_dir  = serve_dir_q;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign paused     = paused_q;

endmodule
